// File: rtl/spi_regfile_pkg.sv
// -----------------------------------------------------------------------------
// spi_regfile_pkg
// Shared types and helpers for the SPI register-file peripheral.
//   spi_state_t : frame FSM states (IDLE, CMD, DATA, WAIT_END)
//   RW_WRITE    : value of the leading R/W bit that marks a write frame
//   frame_len() : total SCLK bits in one frame (R/W + address + data)
//   cnt_width() : bit-counter width able to hold frame_len without wrapping
// -----------------------------------------------------------------------------
package spi_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CMD      = 2'd1,
        DATA     = 2'd2,
        WAIT_END = 2'd3
    } spi_state_t;

    localparam logic RW_WRITE = 1'b1;

    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    function automatic int cnt_width(input int flen);
        return $clog2(flen + 1);
    endfunction

endpackage

// File: rtl/spi_regfile_peripheral_sync.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Multi-flop synchroniser for one asynchronous pin, followed by a history flop
// so rising/falling edges of the synchronised level can be detected.
//   clk, rst_n : system clock, async active-low reset
//   d_in       : asynchronous pin
//   sync_out   : synchronised level (STAGES flops after the pin)
//   rise, fall : single-cycle edge flags of sync_out
// On reset every flop loads IDLE_VAL so no phantom edge appears on release.
// -----------------------------------------------------------------------------
module spi_sync_edge
    import spi_regfile_pkg::*;
#(
    parameter int   STAGES   = 2,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              hist_q;
    logic              hist_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
        hist_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{IDLE_VAL}};
            hist_q <= IDLE_VAL;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign sync_out = sync_q[STAGES-1];
    assign rise     = sync_q[STAGES-1] & ~hist_q;
    assign fall     = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// -----------------------------------------------------------------------------
// spi_regfile_peripheral
// SPI peripheral (mode 0 / mode 2, MSB first) giving a host read/write access
// to NUM_REGS registers of DATA_W bits. Frame: R/W, ADDR_W address, DATA_W data.
//   clk, rst_n : system clock, async active-low reset
//   nCS, SCLK, COPI : asynchronous SPI pins (synchronised internally)
//   CIPO, cipo_oe   : read data out and its enable (0 outside read data phase)
//   regs_out        : flattened bank, register i at [i*DATA_W +: DATA_W]
//   wr_strobe       : one-cycle pulse per register on update
//   frame_err       : one-cycle pulse when a short/overlong frame is dropped
//   dbg_state       : current FSM state for observation
// All outputs are registered.
// -----------------------------------------------------------------------------
module spi_regfile_peripheral
    import spi_regfile_pkg::*;
#(
    parameter int                 NUM_REGS    = 5,
    parameter int                 ADDR_W      = 7,
    parameter int                 DATA_W      = 8,
    parameter int                 SYNC_STAGES = 2,
    parameter logic               CPOL        = 1'b0,
    parameter logic [DATA_W-1:0]  RESET_VAL   = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         nCS,
    input  logic                         SCLK,
    input  logic                         COPI,
    output logic                         CIPO,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         frame_err,
    output spi_state_t                   dbg_state
);

    localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
    localparam int CNT_W     = cnt_width(FRAME_LEN);

    // ---------------- synchronisers ----------------
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic ncs_lvl, cs_rise, cs_fall;
    logic copi_s, copi_rise, copi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(CPOL)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_in(SCLK),
        .sync_out(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d_in(nCS),
        .sync_out(ncs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    // COPI only needs the synchronised level; its edge flags are not used.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d_in(COPI),
        .sync_out(copi_s), .rise(copi_rise), .fall(copi_fall)
    );

    logic unused_sync;
    assign unused_sync = sclk_lvl ^ copi_rise ^ copi_fall;

    // Leading edge samples COPI, trailing edge launches CIPO. SCLK edges seen
    // while the synchronised chip select is high are not part of any frame.
    logic lead_edge, trail_edge;
    assign lead_edge  = (CPOL ? sclk_fall : sclk_rise) & ~ncs_lvl;
    assign trail_edge = (CPOL ? sclk_rise : sclk_fall) & ~ncs_lvl;

    // ---------------- state ----------------
    spi_state_t                          state_q, state_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [FRAME_LEN-1:0]                shift_q, shift_d;
    logic                                rw_q, rw_d;
    logic [ADDR_W-1:0]                   addr_q, addr_d;
    logic                                bad_q, bad_d;
    logic [DATA_W-1:0]                   shadow_q, shadow_d;
    logic                                cipo_q, cipo_d;
    logic                                cipo_oe_q, cipo_oe_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]     regs_q, regs_d;
    logic [NUM_REGS-1:0]                 wr_strobe_q, wr_strobe_d;
    logic                                frame_err_q, frame_err_d;

    logic [FRAME_LEN-1:0]                shift_next;
    logic [DATA_W-1:0]                   rd_word;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        bad_d       = bad_q;
        shadow_d    = shadow_q;
        cipo_d      = cipo_q;
        cipo_oe_d   = cipo_oe_q;
        regs_d      = regs_q;
        wr_strobe_d = '0;
        frame_err_d = 1'b0;

        shift_next = {shift_q[FRAME_LEN-2:0], copi_s};

        // Register selected by the address being completed this edge; an
        // unimplemented address matches nothing and reads as zero.
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (shift_next[ADDR_W-1:0] == ADDR_W'(i)) begin
                rd_word = regs_q[i];
            end
        end

        if (cs_rise) begin
            // End of frame has priority over any SCLK edge on the same cycle.
            state_d   = IDLE;
            cipo_d    = 1'b0;
            cipo_oe_d = 1'b0;
            case (state_q)
                CMD, DATA: frame_err_d = 1'b1;
                WAIT_END: begin
                    if (bad_q) begin
                        frame_err_d = 1'b1;
                    end else if (rw_q == RW_WRITE) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (addr_q == ADDR_W'(i)) begin
                                regs_d[i]      = shift_q[DATA_W-1:0];
                                wr_strobe_d[i] = 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d     = '0;
                    shift_d   = '0;
                    bad_d     = 1'b0;
                    shadow_d  = '0;
                    cipo_d    = 1'b0;
                    cipo_oe_d = 1'b0;
                    if (cs_fall) begin
                        state_d = CMD;
                    end
                end
                CMD: begin
                    if (lead_edge) begin
                        shift_d = shift_next;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(ADDR_W)) begin
                            rw_d     = shift_next[ADDR_W];
                            addr_d   = shift_next[ADDR_W-1:0];
                            shadow_d = (shift_next[ADDR_W] == RW_WRITE) ? '0 : rd_word;
                            state_d  = DATA;
                        end
                    end
                end
                DATA: begin
                    if (lead_edge) begin
                        shift_d = shift_next;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                            state_d = WAIT_END;
                        end
                    end else if (trail_edge && (rw_q != RW_WRITE)) begin
                        cipo_d    = shadow_q[DATA_W-1];
                        shadow_d  = shadow_q << 1;
                        cipo_oe_d = 1'b1;
                    end
                end
                WAIT_END: begin
                    // Counter holds at FRAME_LEN; any further bit spoils the frame.
                    if (lead_edge) begin
                        bad_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            bad_q       <= 1'b0;
            shadow_q    <= '0;
            cipo_q      <= 1'b0;
            cipo_oe_q   <= 1'b0;
            regs_q      <= {NUM_REGS{RESET_VAL}};
            wr_strobe_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            bad_q       <= bad_d;
            shadow_q    <= shadow_d;
            cipo_q      <= cipo_d;
            cipo_oe_q   <= cipo_oe_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign CIPO      = cipo_q;
    assign cipo_oe   = cipo_oe_q;
    assign regs_out  = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign frame_err = frame_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
module tb_spi_regfile_peripheral;
    import spi_regfile_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // index 0: default instance (mode 0); index 1: 16x16, ADDR_W=4, CPOL=1
    logic ncs  [2];
    logic sclk [2];
    logic copi [2];

    logic         cipo0, oe0, ferr0;
    logic [39:0]  regs0;
    logic [4:0]   strobe0;
    spi_state_t   st0;

    logic         cipo1, oe1, ferr1;
    logic [255:0] regs1;
    logic [15:0]  strobe1;
    spi_state_t   st1;

    spi_regfile_peripheral dut0 (
        .clk(clk), .rst_n(rst_n), .nCS(ncs[0]), .SCLK(sclk[0]), .COPI(copi[0]),
        .CIPO(cipo0), .cipo_oe(oe0), .regs_out(regs0), .wr_strobe(strobe0),
        .frame_err(ferr0), .dbg_state(st0)
    );

    spi_regfile_peripheral #(
        .NUM_REGS(16), .ADDR_W(4), .DATA_W(16), .CPOL(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .nCS(ncs[1]), .SCLK(sclk[1]), .COPI(copi[1]),
        .CIPO(cipo1), .cipo_oe(oe1), .regs_out(regs1), .wr_strobe(strobe1),
        .frame_err(ferr1), .dbg_state(st1)
    );

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Pulse monitor: counts cycles each strobe/error output is high.
    int          strobe_cyc0 = 0, strobe_cyc1 = 0, ferr_cyc0 = 0, ferr_cyc1 = 0;
    logic [4:0]  last_strobe0 = '0;
    logic [15:0] last_strobe1 = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (strobe0 != '0) begin
                strobe_cyc0  <= strobe_cyc0 + 1;
                last_strobe0 <= strobe0;
            end
            if (strobe1 != '0) begin
                strobe_cyc1  <= strobe_cyc1 + 1;
                last_strobe1 <= strobe1;
            end
            if (ferr0) ferr_cyc0 <= ferr_cyc0 + 1;
            if (ferr1) ferr_cyc1 <= ferr_cyc1 + 1;
        end
    end

    // ---------------- driver ----------------
    task automatic half_period();
        repeat (4) @(negedge clk);
    endtask

    // Drives nbits SCLK periods MSB first; rx collects CIPO at each lead edge.
    task automatic spi_frame(input int sel, input logic [63:0] bits, input int nbits,
                             input bit hold_cs, output logic [63:0] rx, output logic oe_seen);
        logic idle_lvl;
        logic c, o;
        idle_lvl = (sel == 1) ? 1'b1 : 1'b0;
        rx = '0;
        oe_seen = 1'b0;
        ncs[sel] = 1'b0;
        half_period();
        for (int k = 0; k < nbits; k++) begin
            copi[sel] = bits[nbits-1-k];
            half_period();
            c = (sel == 1) ? cipo1 : cipo0;
            o = (sel == 1) ? oe1 : oe0;
            rx = {rx[62:0], c};
            oe_seen = oe_seen | o;
            sclk[sel] = ~idle_lvl;
            half_period();
            sclk[sel] = idle_lvl;
        end
        if (!hold_cs) begin
            half_period();
            ncs[sel]  = 1'b1;
            copi[sel] = 1'b0;
            repeat (12) @(negedge clk);
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int          sel;
        logic [63:0] bits;
        int          nbits;
        int          strobes;
        logic [15:0] strobe_val;
        int          ferrs;
        bit          upd;
        int          upd_idx;
        logic [15:0] upd_val;
        bit          is_read;
        logic [15:0] rd_val;
    } vec_t;

    vec_t        vecs[10];
    logic [39:0]  bank0;
    logic [255:0] bank1;
    logic [63:0]  rx;
    logic         oe_seen;
    int           b_s0, b_s1, b_f0, b_f1;
    int           d_str, d_ferr;
    logic [15:0]  got_strobe, got_rd, exp_rd;

    initial begin
        //            sel bits          nb  str sval     fe upd idx uval     rd rdval
        vecs[0] = '{0, 64'h84B3,      16, 1, 16'h0010, 0, 1, 4,  16'h00B3, 0, 16'h0000}; // write reg4 B3
        vecs[1] = '{0, 64'h825A,      16, 1, 16'h0004, 0, 1, 2,  16'h005A, 0, 16'h0000}; // write reg2 5A
        vecs[2] = '{0, 64'h02FF,      16, 0, 16'h0000, 0, 0, 0,  16'h0000, 1, 16'h005A}; // read reg2
        vecs[3] = '{0, 64'h0200,      10, 0, 16'h0000, 1, 0, 0,  16'h0000, 0, 16'h0000}; // short write reg0
        vecs[4] = '{0, 64'h10386,     17, 0, 16'h0000, 1, 0, 0,  16'h0000, 0, 16'h0000}; // long write reg1
        vecs[5] = '{0, 64'hFFFF,      16, 0, 16'h0000, 0, 0, 0,  16'h0000, 0, 16'h0000}; // write addr 7F
        vecs[6] = '{0, 64'h10AA,      16, 0, 16'h0000, 0, 0, 0,  16'h0000, 1, 16'h0000}; // read addr 10
        vecs[7] = '{0, 64'h0400,      16, 0, 16'h0000, 0, 0, 0,  16'h0000, 1, 16'h00B3}; // read reg4
        vecs[8] = '{1, 64'h1FBEEF,    21, 1, 16'h8000, 0, 1, 15, 16'hBEEF, 0, 16'h0000}; // sweep write
        vecs[9] = '{1, 64'h0F0000,    21, 0, 16'h0000, 0, 0, 0,  16'h0000, 1, 16'hBEEF}; // sweep read

        bank0 = '0;
        bank1 = '0;

        rst_n   = 1'b0;
        ncs[0]  = 1'b1; sclk[0] = 1'b0; copi[0] = 1'b0;
        ncs[1]  = 1'b1; sclk[1] = 1'b1; copi[1] = 1'b0;
        repeat (4) @(negedge clk);

        // reset state
        check("rst_regs0",  256'(regs0), 256'(0));
        check("rst_regs1",  regs1, 256'(0));
        check("rst_outs0",  256'({cipo0, oe0, ferr0, strobe0}), 256'(0));
        check("rst_state0", 256'({st0}), 256'({IDLE}));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            b_s0 = strobe_cyc0; b_s1 = strobe_cyc1;
            b_f0 = ferr_cyc0;   b_f1 = ferr_cyc1;
            if (vecs[i].is_read) exp_q.push_back(vecs[i].rd_val);
            spi_frame(vecs[i].sel, vecs[i].bits, vecs[i].nbits, 1'b0, rx, oe_seen);

            if (vecs[i].upd) begin
                if (vecs[i].sel == 0) bank0[vecs[i].upd_idx*8 +: 8] = vecs[i].upd_val[7:0];
                else                  bank1[vecs[i].upd_idx*16 +: 16] = vecs[i].upd_val;
            end

            if (vecs[i].sel == 0) begin
                d_str = strobe_cyc0 - b_s0;
                d_ferr = ferr_cyc0 - b_f0;
                got_strobe = {11'b0, last_strobe0};
                got_rd = {8'b0, rx[7:0]};
                check($sformatf("v%0d_regs", i), 256'(regs0), 256'(bank0));
                check($sformatf("v%0d_cipo_idle", i), 256'({cipo0, oe0}), 256'(0));
            end else begin
                d_str = strobe_cyc1 - b_s1;
                d_ferr = ferr_cyc1 - b_f1;
                got_strobe = last_strobe1;
                got_rd = rx[15:0];
                check($sformatf("v%0d_regs", i), regs1, bank1);
                check($sformatf("v%0d_cipo_idle", i), 256'({cipo1, oe1}), 256'(0));
            end
            check($sformatf("v%0d_strobe_cycles", i), 256'(d_str), 256'(vecs[i].strobes));
            check($sformatf("v%0d_ferr_cycles", i), 256'(d_ferr), 256'(vecs[i].ferrs));
            if (vecs[i].strobes == 1)
                check($sformatf("v%0d_strobe_val", i), 256'(got_strobe), 256'(vecs[i].strobe_val));
            check($sformatf("v%0d_oe_seen", i), 256'(oe_seen), 256'(vecs[i].is_read));
            if (vecs[i].is_read) begin
                exp_rd = exp_q.pop_front();
                check($sformatf("v%0d_read_data", i), 256'(got_rd), 256'(exp_rd));
            end
        end

        // Reset during bit 12 of a write to reg0: outputs clear immediately.
        spi_frame(0, 64'h8077 >> 4, 12, 1'b1, rx, oe_seen);
        rst_n = 1'b0;
        #1;
        check("midrst_regs0",  256'(regs0), 256'(0));
        check("midrst_regs1",  regs1, 256'(0));
        check("midrst_outs0",  256'({cipo0, oe0, ferr0, strobe0}), 256'(0));
        check("midrst_state0", 256'({st0}), 256'({IDLE}));
        bank0 = '0;
        bank1 = '0;
        ncs[0]  = 1'b1;
        copi[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Full frame after release writes reg0 = 0x77.
        b_s0 = strobe_cyc0;
        b_f0 = ferr_cyc0;
        spi_frame(0, 64'h8077, 16, 1'b0, rx, oe_seen);
        bank0[7:0] = 8'h77;
        check("postrst_regs0", 256'(regs0), 256'(bank0));
        check("postrst_strobe_cycles", 256'(strobe_cyc0 - b_s0), 256'(1));
        check("postrst_strobe_val", 256'(last_strobe0), 256'(5'b00001));
        check("postrst_ferr_cycles", 256'(ferr_cyc0 - b_f0), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
